// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - oversampled SPI-slave register bank, all CPOL/CPHA modes, burst auto-increment
// Optional SPI_BANK_SNAPSHOT_EN: status registers captured into a shadow bank at chip-select fall.
module spi_reg_bank #(
    parameter int NUM_CFG     = 2,
    parameter int NUM_STATUS  = 2,
    parameter int REG_WIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic                             spi_miso_oe,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic [NUM_CFG-1:0]               cfg_wr_stb,
    output logic                             busy
);
    localparam int W  = REG_WIDTH;
    localparam int CW = $clog2(REG_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    logic [4:0]                  sync_q [SYNC_STAGES];
    state_t                      state_q;
    logic                        cs_prev_q, sclk_prev_q;
    logic [1:0]                  mode_q;
    logic [CW-1:0]               cnt_q;
    logic [W-1:0]                rx_q, tx_q;
    logic [6:0]                  addr_q;
    logic                        wr_q;
    logic                        miso_q, oe_q, busy_q;
    logic [NUM_CFG*W-1:0]        cfg_q;
    logic [NUM_CFG-1:0]          stb_q;
    logic [NUM_STATUS*W-1:0]     stat_src;

    logic       cs_s, sclk_s, mosi_s;
    logic [1:0] mode_s;
    logic       cs_fall, cs_rise, sclk_rise, sclk_fall, leading, trailing;
    logic       sample_edge, shift_edge, last_cmd, last_data;
    logic [W-1:0] rx_d, rd_word;
    logic [6:0]   load_addr;

    // Every async input, mode included, goes through the same-depth chain so data stays aligned to sclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {mode, spi_mosi, spi_clk, spi_cs_n};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {mode_s, mosi_s, sclk_s, cs_s} = sync_q[SYNC_STAGES-1];

    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign sclk_rise   = ~sclk_prev_q & sclk_s;
    assign sclk_fall   = sclk_prev_q & ~sclk_s;
    assign leading     = mode_q[1] ? sclk_fall : sclk_rise;
    assign trailing    = mode_q[1] ? sclk_rise : sclk_fall;
    assign sample_edge = mode_q[0] ? trailing : leading;
    assign shift_edge  = mode_q[0] ? leading : trailing;
    assign rx_d        = {rx_q[W-2:0], mosi_s};
    assign last_cmd    = (state_q == S_CMD)  && (cnt_q == CW'(7));
    assign last_data   = (state_q == S_DATA) && (cnt_q == CW'(W-1));
    assign load_addr   = (state_q == S_CMD) ? rx_d[6:0] : addr_q + 7'd1;

`ifdef SPI_BANK_SNAPSHOT_EN
    logic [NUM_STATUS*W-1:0] shadow_q;
    always_ff @(posedge clk) begin
        if (rst)
            shadow_q <= '0;
        else if (state_q == S_IDLE && cs_fall)
            shadow_q <= status_regs;
    end
    assign stat_src = shadow_q;
`else
    assign stat_src = status_regs;
`endif

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (load_addr == 7'(i)) rd_word = cfg_q[i*W +: W];
        for (int j = 0; j < NUM_STATUS; j++)
            if (load_addr == 7'(NUM_CFG + j)) rd_word = stat_src[j*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mode_q      <= 2'b00;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            cfg_q       <= CFG_RESET;
            stb_q       <= '0;
        end else begin
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            stb_q       <= '0;
            if (cs_rise) begin
                state_q <= S_IDLE;
                miso_q  <= 1'b0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (state_q == S_IDLE) begin
                if (cs_fall) begin
                    state_q <= S_CMD;
                    mode_q  <= mode_s;
                    cnt_q   <= '0;
                    rx_q    <= '0;
                    tx_q    <= '0;
                    miso_q  <= 1'b0;
                    oe_q    <= 1'b1;
                    busy_q  <= 1'b1;
                end
            end else begin
                if (shift_edge) begin
                    miso_q <= tx_q[W-1];
                    tx_q   <= {tx_q[W-2:0], 1'b0};
                end
                if (sample_edge) begin
                    rx_q <= rx_d;
                    if (last_cmd) begin
                        state_q <= S_DATA;
                        wr_q    <= rx_d[7];
                        addr_q  <= rx_d[6:0];
                        tx_q    <= rd_word;
                        cnt_q   <= '0;
                    end else if (last_data) begin
                        // Only complete words commit; status and out-of-range addresses fall through.
                        for (int i = 0; i < NUM_CFG; i++) begin
                            if (wr_q && addr_q == 7'(i)) begin
                                cfg_q[i*W +: W] <= rx_d;
                                stb_q[i]        <= 1'b1;
                            end
                        end
                        addr_q <= addr_q + 7'd1;
                        tx_q   <= rd_word;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign busy        = busy_q;
    assign config_regs = cfg_q;
    assign cfg_wr_stb  = stb_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - table-driven bench for spi_reg_bank in all four SPI modes
module tb_spi_reg_bank;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        spi_cs_n, spi_clk, spi_mosi;
    logic        spi_miso, spi_miso_oe, busy;
    logic [15:0] config_regs;
    logic [15:0] status_regs;
    logic [1:0]  cfg_wr_stb;

    always #5 clk = ~clk;

    spi_reg_bank #(.NUM_CFG(2), .NUM_STATUS(2), .REG_WIDTH(8), .SYNC_STAGES(2),
                   .CFG_RESET(16'h5AC3)) dut (
        .clk(clk), .rst(rst), .mode(mode), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .config_regs(config_regs), .status_regs(status_regs),
        .cfg_wr_stb(cfg_wr_stb), .busy(busy)
    );

    int   errors = 0;
    int   checks = 0;
    int   stb0_n = 0, stb1_n = 0;
    logic stb_long = 1'b0;
    logic [1:0] stb_prev = 2'b00;
    logic [31:0] rx_acc;
    logic mid_busy, mid_oe;

    always @(negedge clk) begin
        if (cfg_wr_stb[0]) stb0_n++;
        if (cfg_wr_stb[1]) stb1_n++;
        if (|(cfg_wr_stb & stb_prev)) stb_long = 1'b1;
        stb_prev = cfg_wr_stb;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input logic [1:0] m, input int nbits, input logic [31:0] tx);
        mode     = m;
        spi_clk  = m[1];
        spi_mosi = 1'b0;
        rx_acc   = '0;
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b == 3) begin
                mid_busy = busy;
                mid_oe   = spi_miso_oe;
            end
            if (!m[0]) begin
                spi_mosi = tx[nbits-1-b];
                repeat (HALF) @(negedge clk);
                rx_acc  = {rx_acc[30:0], spi_miso};
                spi_clk = ~m[1];
                repeat (HALF) @(negedge clk);
                spi_clk = m[1];
            end else begin
                spi_clk  = ~m[1];
                spi_mosi = tx[nbits-1-b];
                repeat (HALF) @(negedge clk);
                rx_acc  = {rx_acc[30:0], spi_miso};
                spi_clk = m[1];
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  m;
        int          nbits;
        logic [31:0] tx;
        logic [15:0] exp_cfg;
        int          exp_s0;
        int          exp_s1;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int s0, s1;
        logic [31:0] exp_chg;

        vecs[0]  = '{2'd0, 16, 32'h000080A5, 16'h5AA5, 1, 0, 32'h000000C3};
        vecs[1]  = '{2'd1, 16, 32'h0000813C, 16'h3CA5, 0, 1, 32'h0000005A};
        vecs[2]  = '{2'd1, 16, 32'h00000100, 16'h3CA5, 0, 0, 32'h0000003C};
        vecs[3]  = '{2'd2, 16, 32'h0000814D, 16'h4DA5, 0, 1, 32'h0000003C};
        vecs[4]  = '{2'd2, 16, 32'h00000100, 16'h4DA5, 0, 0, 32'h0000004D};
        vecs[5]  = '{2'd3, 16, 32'h0000813C, 16'h3CA5, 0, 1, 32'h0000004D};
        vecs[6]  = '{2'd3, 16, 32'h00000100, 16'h3CA5, 0, 0, 32'h0000003C};
        vecs[7]  = '{2'd3, 16, 32'h00000000, 16'h3CA5, 0, 0, 32'h000000A5};
        vecs[8]  = '{2'd0, 32, 32'h80112233, 16'h2211, 1, 1, 32'h00A53C10};
        vecs[9]  = '{2'd0, 24, 32'h00020000, 16'h2211, 0, 0, 32'h00001077};
        vecs[10] = '{2'd3, 24, 32'h007F0000, 16'h2211, 0, 0, 32'h00000011};
        vecs[11] = '{2'd0, 16, 32'h000083FF, 16'h2211, 0, 0, 32'h00000077};
        vecs[12] = '{2'd1, 16, 32'h00008455, 16'h2211, 0, 0, 32'h00000000};
        vecs[13] = '{2'd0, 13, 32'h0000100B, 16'h2211, 0, 0, 32'h00000002};
        vecs[14] = '{2'd0, 16, 32'h000080C7, 16'h22C7, 1, 0, 32'h00000011};
        vecs[15] = '{2'd2, 32, 32'h00000000, 16'h22C7, 0, 0, 32'h00C72210};

        rst = 1'b1; mode = 2'b00; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        status_regs = 16'h7710;
        repeat (4) @(negedge clk);
        chk("reset_cfg", 32'(config_regs), 32'h5AC3);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_oe", 32'(spi_miso_oe), 32'h0);
        chk("reset_miso", 32'(spi_miso), 32'h0);
        chk("reset_stb", 32'(cfg_wr_stb), 32'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 16; v++) begin
            s0 = stb0_n; s1 = stb1_n;
            mid_busy = 1'b0; mid_oe = 1'b0;
            spi_frame(vecs[v].m, vecs[v].nbits, vecs[v].tx);
            chk($sformatf("v%0d_cfg", v), 32'(config_regs), 32'(vecs[v].exp_cfg));
            chk($sformatf("v%0d_stb0", v), 32'(stb0_n - s0), 32'(vecs[v].exp_s0));
            chk($sformatf("v%0d_stb1", v), 32'(stb1_n - s1), 32'(vecs[v].exp_s1));
            chk($sformatf("v%0d_miso", v), rx_acc, vecs[v].exp_rx);
            chk($sformatf("v%0d_busy_mid", v), 32'(mid_busy), 32'h1);
            chk($sformatf("v%0d_oe_mid", v), 32'(mid_oe), 32'h1);
            chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
            chk($sformatf("v%0d_oe_end", v), 32'(spi_miso_oe), 32'h0);
            chk($sformatf("v%0d_stb_width", v), 32'(stb_long), 32'h0);
        end

        // Status change during the command phase, before the data word is loaded.
`ifdef SPI_BANK_SNAPSHOT_EN
        exp_chg = 32'h00000010;
`else
        exp_chg = 32'h00000020;
`endif
        fork
            spi_frame(2'd0, 16, 32'h00000200);
            begin
                repeat (60) @(negedge clk);
                status_regs[7:0] = 8'h20;
            end
        join
        chk("status_chg_cmd", rx_acc, exp_chg);
        status_regs[7:0] = 8'h10;
        repeat (4) @(negedge clk);

        // Status change after the load boundary never disturbs bits in flight.
        fork
            spi_frame(2'd0, 16, 32'h00000200);
            begin
                repeat (180) @(negedge clk);
                status_regs[7:0] = 8'h20;
            end
        join
        chk("status_chg_data", rx_acc, 32'h00000010);
        status_regs[7:0] = 8'h10;
        repeat (4) @(negedge clk);

        // Reset in the middle of a burst write, before the first word completes.
        s0 = stb0_n; s1 = stb1_n;
        fork
            spi_frame(2'd0, 32, 32'h80999897);
            begin
                repeat (200) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_cfg", 32'(config_regs), 32'h5AC3);
                chk("rst_mid_busy", 32'(busy), 32'h0);
                chk("rst_mid_oe", 32'(spi_miso_oe), 32'h0);
                chk("rst_mid_miso", 32'(spi_miso), 32'h0);
                chk("rst_mid_stb", 32'(cfg_wr_stb), 32'h0);
            end
        join
        chk("rst_after_cfg", 32'(config_regs), 32'h5AC3);
        chk("rst_after_stb", 32'((stb0_n - s0) + (stb1_n - s1)), 32'h0);
        chk("rst_after_busy", 32'(busy), 32'h0);

        s0 = stb0_n; s1 = stb1_n;
        spi_frame(2'd0, 16, 32'h00008142);
        chk("post_rst_cfg", 32'(config_regs), 32'h42C3);
        chk("post_rst_stb1", 32'(stb1_n - s1), 32'h1);
        chk("post_rst_stb0", 32'(stb0_n - s0), 32'h0);
        chk("post_rst_miso", rx_acc, 32'h0000005A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
